// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Contents:
//   state_t   - arbiter FSM state (IDLE / OWNED)
//   IDX_W     - index width for the default requester count
//   rr_search - rotate-and-priority search over a request vector (max 16)
package rr_reg_arbiter_pkg;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned N_DEF   = 4;
  localparam int unsigned IDX_W   = $clog2(N_DEF);

  // Returns {found, index}. The search visits start, start+1, ... wrapping
  // at n; the first set bit wins.
  function automatic logic [4:0] rr_search(input logic [MAX_REQ-1:0] r,
                                           input int unsigned n,
                                           input int unsigned start);
    logic [4:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !res[4]) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (r[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side bus of the round-robin register arbiter.
// Signals:
//   req     - per-requester ownership request (level)
//   we      - per-requester write enable
//   wdata   - packed write data, slice i = wdata[i*WIDTH +: WIDTH]
//   gnt     - registered one-hot-or-zero grant
//   owner   - index of current/last owner
//   q       - shared register contents
//   q_valid - a write has been accepted since reset
// Modports: master = requesters, slave = arbiter.
interface rr_reg_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  logic [N-1:0]         req;
  logic [N-1:0]         we;
  logic [N*WIDTH-1:0]   wdata;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] owner;
  logic [WIDTH-1:0]     q;
  logic                 q_valid;

  modport master (output req, we, wdata, input gnt, owner, q, q_valid);
  modport slave  (input req, we, wdata, output gnt, owner, q, q_valid);
endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector
//   start - first index searched
//   excl  - requesters removed from the search
//   win   - winning index (valid when found)
//   found - some non-excluded request is set
module rr_pick
  import rr_reg_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic [N-1:0]         excl,
  output logic [$clog2(N)-1:0] win,
  output logic                 found
);
  localparam int unsigned IW = $clog2(N);

  logic [MAX_REQ-1:0] r_ext;
  logic [4:0]         res;

  always_comb begin
    r_ext        = '0;
    r_ext[N-1:0] = req & ~excl;
    res          = rr_search(r_ext, N, int'(start));
    found        = res[4];
    win          = res[IW-1:0];
  end
endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among N requesters.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - rr_reg_arbiter_if.slave (req/we/wdata in, gnt/owner/q/q_valid out)
// A requester may hold ownership for at most MAX_HOLD consecutive cycles
// while someone else waits; it is then rotated out and re-queued.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst,
  rr_reg_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  last_q, last_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic           valid_q, valid_d;

  logic [IW-1:0]  pick_start;
  logic [N-1:0]   pick_excl;
  logic [IW-1:0]  pick_idx;
  logic           pick_found;
  logic           wr_en;

  // One picker covers both the normal search and forced rotation: while
  // owned, the owner is excluded, which only matters when it still requests.
  always_comb begin
    pick_start = (last_q == LAST_RST) ? '0 : last_q + IW'(1);
    pick_excl  = (state_q == OWNED) ? (N'(1) << owner_q) : '0;
  end

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .start (pick_start),
    .excl  (pick_excl),
    .win   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          gnt_d   = N'(1) << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          hold_d  = HOLD_ONE;
        end
      end
      OWNED: begin
        if (!bus.req[owner_q] || (hold_q == HOLD_MAX)) begin
          if (pick_found) begin
            gnt_d   = N'(1) << pick_idx;
            owner_d = pick_idx;
            last_d  = pick_idx;
            hold_d  = HOLD_ONE;
          end else if (!bus.req[owner_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // gnt_q is one-hot on owner_q, so the owner index selects the write slice.
  always_comb begin
    wr_en   = |(gnt_q & bus.we);
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d  = bus.wdata[owner_q*WIDTH +: WIDTH];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.q       = data_q;
  assign bus.q_valid = valid_q;
endmodule
